// File: rtl/upc_pkg.sv
// Shared types for the checkout scan path: scan FSM states and the captured
// item code, which the downstream stolen/discounted decoders also use.
package upc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        WAIT_REL = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic m;
        logic u;
        logic p;
        logic c;
    } upc_code_t;

    localparam upc_code_t UPC_CODE_NONE = '{m: 1'b0, u: 1'b0, p: 1'b0, c: 1'b0};

    // Raw switch bundle {mark, U, P, C} into the packed code layout.
    function automatic upc_code_t upc_from_raw(input logic [3:0] raw);
        upc_code_t code;
        code.m = raw[3];
        code.u = raw[2];
        code.p = raw[1];
        code.c = raw[0];
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, with a per-instance
// reset value so an idle pushbutton can come out of reset as "released".
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Shift the asynchronous input through two flops into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/upc_scan_capture.sv
// Scan capture front end: synchronises the scan key and item switches,
// debounces the key, latches {M,U,P,C} once per fresh press and holds the
// result valid for a fixed time so switch wiggle never reaches the decoders.
module upc_scan_capture
    import upc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 250_000_000,
    parameter int CNT_W           = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic [2:0] upc_in,
    input  logic       mark_in,
    output logic       U,
    output logic       P,
    output logic       C,
    output logic       M,
    output logic       scan_valid,
    output logic       scan_pulse,
    output logic [7:0] scan_count
);

    // The counter holds how many consecutive low key samples were already seen
    // in DEBOUNCE, so the sample arriving with cnt == DEBOUNCE_CYCLES-1 is the
    // last one needed. In HOLD it counts cycles since the hold started.
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'sd1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 32'sd1);
    localparam logic             HOLD_EN    = (HOLD_CYCLES != 32'sd0);
    localparam logic             DEB_SINGLE = (DEBOUNCE_CYCLES == 32'sd1);

    logic       key_s;
    logic [3:0] data_s;

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    upc_code_t        code_q, code_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;
    logic [7:0]       count_q, count_d;
    logic             armed_q, armed_d;
    logic             start_s;
    logic             capture_s;

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (key_n),
        .q_o   (key_s)
    );

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'b0000)) u_data_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   ({mark_in, upc_in}),
        .q_o   (data_s)
    );

    // Next-state logic: debounce, capture, hold timing and re-arm on release.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        valid_d   = valid_q;
        pulse_d   = 1'b0;
        count_d   = count_q;
        armed_d   = armed_q | key_s;
        start_s   = 1'b0;
        capture_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DEBOUNCE: begin
                if (key_s) begin
                    // Bounce: abandon the attempt; an existing capture keeps showing.
                    cnt_d   = CNT_ZERO;
                    state_d = valid_q ? HOLD : IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    capture_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (!key_s && armed_q) begin
                    // Fresh press while displaying: old code stays until it captures.
                    start_s = 1'b1;
                end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
                    valid_d = 1'b0;
                    code_d  = UPC_CODE_NONE;
                    cnt_d   = CNT_ZERO;
                    state_d = key_s ? IDLE : WAIT_REL;
                end else if (HOLD_EN) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            WAIT_REL: begin
                if (key_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_REL;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // The sample that starts a press is the first debounce sample.
        if (start_s) begin
            if (DEB_SINGLE) begin
                capture_s = 1'b1;
            end else begin
                state_d = DEBOUNCE;
                cnt_d   = CNT_ONE;
            end
        end else begin
            start_s = 1'b0;
        end

        // Capture overrides any hold expiry decided above.
        if (capture_s) begin
            code_d  = upc_from_raw(data_s);
            valid_d = 1'b1;
            pulse_d = 1'b1;
            count_d = count_q + 8'd1;
            state_d = HOLD;
            cnt_d   = CNT_ZERO;
            armed_d = 1'b0;
        end else begin
            pulse_d = 1'b0;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            code_q  <= UPC_CODE_NONE;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= 8'd0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

    assign U          = code_q.u;
    assign P          = code_q.p;
    assign C          = code_q.c;
    assign M          = code_q.m;
    assign scan_valid = valid_q;
    assign scan_pulse = pulse_q;
    assign scan_count = count_q;

endmodule

// File: tb/tb_upc_scan_capture.sv
// Bench for upc_scan_capture with short debounce/hold times. A behavioural
// model (key history, low-run length, hold timestamps) predicts all outputs
// every cycle; directed scenarios add hand-computed literal expectations.
module tb_upc_scan_capture;

    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_n;
    logic [2:0] upc_in;
    logic       mark_in;
    logic       U, P, C, M;
    logic       scan_valid, scan_pulse;
    logic [7:0] scan_count;

    upc_scan_capture #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .CNT_W           (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .upc_in     (upc_in),
        .mark_in    (mark_in),
        .U          (U),
        .P          (P),
        .C          (C),
        .M          (M),
        .scan_valid (scan_valid),
        .scan_pulse (scan_pulse),
        .scan_count (scan_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         cyc = 0;
    logic       k1, k2, r1, r2;
    logic [3:0] d1, d2;
    int         low_run, hold_ref;
    logic       e_valid, e_pulse;
    logic [3:0] e_code;
    logic [7:0] e_count;

    // Rules: the key seen by the logic is key_n delayed two edges. A capture
    // happens on the DEB-th consecutive low observation. A capture stays valid
    // HOLD edges after it, except that an aborted press attempt restarts the
    // hold time and no expiry happens while an attempt is in progress.
    task automatic model_step();
        logic       ks;
        logic [3:0] ds;
        cyc++;
        ks = (r1 || r2) ? 1'b1 : k2;
        ds = (r1 || r2) ? 4'd0 : d2;
        k2 = k1; d2 = d1; r2 = r1;
        k1 = key_n; d1 = {mark_in, upc_in}; r1 = reset;
        if (reset) begin
            low_run = 0; e_valid = 1'b0; e_pulse = 1'b0; e_code = 4'd0; e_count = 8'd0;
            hold_ref = cyc;
        end else begin
            e_pulse = 1'b0;
            if (ks) begin
                if (low_run > 0 && low_run < DEB && e_valid) hold_ref = cyc;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (!ks && low_run == DEB) begin
                e_code = ds; e_valid = 1'b1; e_pulse = 1'b1; e_count = e_count + 8'd1;
                hold_ref = cyc;
            end else if (e_valid && !(!ks && low_run < DEB) && (cyc - hold_ref == HOLD)) begin
                e_valid = 1'b0; e_code = 4'd0;
            end
        end
    endtask

    initial begin
        k1 = 1'b1; k2 = 1'b1; r1 = 1'b1; r2 = 1'b1; d1 = 4'd0; d2 = 4'd0;
        low_run = 0; hold_ref = 0;
        e_valid = 1'b0; e_pulse = 1'b0; e_code = 4'd0; e_count = 8'd0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- compare / event log ----------------
    int         pulse_edges[$];
    logic [3:0] pulse_codes[$];
    int         drop_edges[$];
    logic [3:0] drop_codes[$];
    logic       prev_valid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            check("model", {M, U, P, C, scan_valid, scan_pulse, scan_count},
                           {e_code, e_valid, e_pulse, e_count});
            if (scan_pulse === 1'b1) begin
                pulse_edges.push_back(cyc);
                pulse_codes.push_back({M, U, P, C});
            end
            if (prev_valid === 1'b1 && scan_valid === 1'b0) begin
                drop_edges.push_back(cyc);
                drop_codes.push_back({M, U, P, C});
            end
            prev_valid = scan_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic k, input logic m, input logic [2:0] u, input int n);
        key_n = k; mark_in = m; upc_in = u;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        pulse_edges.delete(); pulse_codes.delete();
        drop_edges.delete();  drop_codes.delete();
    endtask

    function automatic int first_or_neg(input int q[$]);
        return (q.size() > 0) ? q[0] : -1000;
    endfunction

    int fall;

    initial begin
        reset = 1'b1; key_n = 1'b0; mark_in = 1'b1; upc_in = 3'b111;

        // 1: reset with key pressed and all switches on
        drive(1'b0, 1'b1, 3'b111, 3);
        check("rst_outputs", {M, U, P, C, scan_valid, scan_pulse, scan_count}, 14'd0);
        reset = 1'b0;
        drive(1'b0, 1'b1, 3'b111, 1);
        drive(1'b1, 1'b1, 3'b111, 6);
        check("rst_no_pulse", pulse_edges.size(), 0);

        // bounce: low 2, high 1, low 2, high
        clear_log();
        drive(1'b0, 1'b0, 3'b000, 2);
        drive(1'b1, 1'b0, 3'b000, 1);
        drive(1'b0, 1'b0, 3'b000, 2);
        drive(1'b1, 1'b0, 3'b000, 8);
        check("bounce_no_pulse", pulse_edges.size(), 0);
        check("bounce_count", scan_count, 8'd0);

        // clean press 101/M=1, then switch wiggle through the hold
        clear_log();
        fall = cyc + 1;
        for (int i = 0; i < 32; i++) begin
            if (i < 8) drive(1'b0, 1'b1, 3'b101, 1);
            else drive((i < 20) ? 1'b0 : 1'b1, i[0], i[0] ? 3'b010 : 3'b101, 1);
        end
        check("press_pulses", pulse_edges.size(), 1);
        check("press_latency", first_or_neg(pulse_edges) - fall + 1, 6);
        check("press_code", (pulse_codes.size() > 0) ? pulse_codes[0] : 4'hx, 4'b1101);
        check("press_count", scan_count, 8'd1);
        check("hold_len", first_or_neg(drop_edges) - first_or_neg(pulse_edges), HOLD);
        check("drop_code", (drop_codes.size() > 0) ? drop_codes[0] : 4'hx, 4'b0000);

        // held key: one capture only, expiry while held, then release and re-press
        clear_log();
        drive(1'b0, 1'b0, 3'b110, 46);
        check("held_one_pulse", pulse_edges.size(), 1);
        check("held_drop", drop_edges.size(), 1);
        drive(1'b1, 1'b0, 3'b110, 5);
        drive(1'b0, 1'b1, 3'b100, 10);
        drive(1'b1, 1'b1, 3'b100, 3);
        check("repress_pulses", pulse_edges.size(), 2);
        check("repress_count", scan_count, 8'd3);

        // rescan during hold with 011: valid must not drop
        clear_log();
        drive(1'b0, 1'b0, 3'b011, 8);
        drive(1'b1, 1'b0, 3'b011, 4);
        check("rescan_pulse", pulse_edges.size(), 1);
        check("rescan_code", (pulse_codes.size() > 0) ? pulse_codes[0] : 4'hx, 4'b0011);
        check("rescan_no_drop", drop_edges.size(), 0);
        check("rescan_count", scan_count, 8'd4);

        // counter wrap
        clear_log();
        for (int s = 0; s < 251; s++) begin
            drive(1'b0, s[1], s[2:0], 5);
            drive(1'b1, s[1], s[2:0], 3);
        end
        check("count_255", scan_count, 8'd255);
        drive(1'b0, 1'b1, 3'b001, 5);
        drive(1'b1, 1'b1, 3'b001, 3);
        check("count_wrap", scan_count, 8'd0);
        check("wrap_pulses", pulse_edges.size(), 252);
        drive(1'b1, 1'b0, 3'b000, 24);
        check("wrap_expired", scan_valid, 1'b0);

        // reset in the middle of debounce
        clear_log();
        drive(1'b0, 1'b1, 3'b111, 3);
        reset = 1'b1;
        drive(1'b0, 1'b1, 3'b111, 2);
        reset = 1'b0;
        drive(1'b1, 1'b1, 3'b111, 8);
        check("rstdeb_no_pulse", pulse_edges.size(), 0);
        check("rstdeb_count", scan_count, 8'd0);
        drive(1'b0, 1'b0, 3'b010, 6);
        drive(1'b1, 1'b0, 3'b010, 4);
        check("after_rst_count", scan_count, 8'd1);
        check("after_rst_code", {M, U, P, C}, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
